// File: rtl/unidade_controle_geogenius_pkg.sv
// Types shared by the GeoGenius control unit and the datapath debug decoder.
package geogenius_pkg;

    typedef enum logic [3:0] {
        INICIAL  = 4'd0,
        PREPARA  = 4'd1,
        ESPERA   = 4'd2,
        REGISTRA = 4'd3,
        COMPARA  = 4'd4,
        ACERTO   = 4'd5,
        ERRO     = 4'd6,
        MOSTRA   = 4'd7,
        PROXIMA  = 4'd8,
        FIM      = 4'd9
    } estado_t;

    localparam int MAX_ERROS_DEFAULT = 1;

    typedef struct packed {
        logic zera_contador_jogada;
        logic zera_contador_score;
        logic zera_timer_resultado;
        logic zera_timeout;
        logic zeraR;
        logic zera_tempo_de_jogo;
        logic conta_jogada;
        logic conta_score;
        logic conta_timer_resultado;
        logic conta_timeout;
        logic registraR;
        logic liga_led;
        logic mostra_tempo_de_jogo;
        logic acertou;
        logic errou;
        logic pronto;
    } saidas_t;

    function automatic logic [3:0] incr_sat(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/unidade_controle_geogenius_if.sv
// Control-unit <-> datapath bundle: status flags in, strobes and indications out.
interface unidade_controle_geogenius_if;

    logic       iniciar;
    logic       fez_jogada;
    logic       jogada_igual_memoria;
    logic       deu_timeout;
    logic       ultima_jogada;
    logic       fim_timer_resultado;

    logic       zera_contador_jogada;
    logic       zera_contador_score;
    logic       zera_timer_resultado;
    logic       zera_timeout;
    logic       zeraR;
    logic       zera_tempo_de_jogo;
    logic       conta_jogada;
    logic       conta_score;
    logic       conta_timer_resultado;
    logic       conta_timeout;
    logic       registraR;
    logic       liga_led;
    logic       mostra_tempo_de_jogo;
    logic       acertou;
    logic       errou;
    logic       pronto;
    logic [3:0] db_estado;

    modport master (
        input  iniciar, fez_jogada, jogada_igual_memoria, deu_timeout,
               ultima_jogada, fim_timer_resultado,
        output zera_contador_jogada, zera_contador_score, zera_timer_resultado,
               zera_timeout, zeraR, zera_tempo_de_jogo, conta_jogada, conta_score,
               conta_timer_resultado, conta_timeout, registraR, liga_led,
               mostra_tempo_de_jogo, acertou, errou, pronto, db_estado
    );

    modport slave (
        output iniciar, fez_jogada, jogada_igual_memoria, deu_timeout,
               ultima_jogada, fim_timer_resultado,
        input  zera_contador_jogada, zera_contador_score, zera_timer_resultado,
               zera_timeout, zeraR, zera_tempo_de_jogo, conta_jogada, conta_score,
               conta_timer_resultado, conta_timeout, registraR, liga_led,
               mostra_tempo_de_jogo, acertou, errou, pronto, db_estado
    );

endinterface

// File: rtl/unidade_controle_geogenius.sv
// Moore control unit sequencing one 8-play GeoGenius round with an error limit.
// Define GEOGENIUS_TEMPO_DE_JOGO_EN to drive zera_tempo_de_jogo/mostra_tempo_de_jogo.
//
// state    | meaning
// INICIAL  | idle, waiting for iniciar
// PREPARA  | clear datapath, error counter and result flag
// ESPERA   | LED on, timeout running, waiting for a play
// REGISTRA | load the play into the datapath register
// COMPARA  | compare the registered play with memory
// ACERTO   | count score, result flag = 1
// ERRO     | count an error, result flag = 0
// MOSTRA   | show acertou/errou until the result timer expires
// PROXIMA  | advance to the next play
// FIM      | game over, pronto asserted until iniciar
module unidade_controle_geogenius
    import geogenius_pkg::*;
#(
    parameter int MAX_ERROS = MAX_ERROS_DEFAULT
) (
    input  logic                         clock,
    input  logic                         reset,
    unidade_controle_geogenius_if.master bus
);

`ifdef GEOGENIUS_TEMPO_DE_JOGO_EN
    localparam logic TEMPO_EN = 1'b1;
`else
    localparam logic TEMPO_EN = 1'b0;
`endif

    localparam logic [3:0] MAX_ERROS_4 = 4'(MAX_ERROS);

    estado_t    estado_q, estado_d;
    logic [3:0] erros_q, erros_d;
    logic       flag_q, flag_d;
    saidas_t    saidas_q, saidas_d;

    // Outputs are registered from the next state, so they always equal a decode of estado_q.
    function automatic saidas_t decodifica(input estado_t e, input logic f);
        saidas_t s;
        s = '0;
        case (e)
            PREPARA: begin
                s.zera_contador_jogada = 1'b1;
                s.zera_contador_score  = 1'b1;
                s.zera_timer_resultado = 1'b1;
                s.zera_timeout         = 1'b1;
                s.zeraR                = 1'b1;
                s.zera_tempo_de_jogo   = TEMPO_EN;
            end
            ESPERA: begin
                s.liga_led      = 1'b1;
                s.conta_timeout = 1'b1;
            end
            REGISTRA: begin
                s.registraR    = 1'b1;
                s.zera_timeout = 1'b1;
            end
            ACERTO: begin
                s.conta_score          = 1'b1;
                s.zera_timer_resultado = 1'b1;
            end
            ERRO: begin
                s.zera_timer_resultado = 1'b1;
                s.zera_timeout         = 1'b1;
            end
            MOSTRA: begin
                s.conta_timer_resultado = 1'b1;
                s.acertou               = f;
                s.errou                 = ~f;
            end
            PROXIMA: begin
                s.conta_jogada = 1'b1;
                s.zera_timeout = 1'b1;
                s.zeraR        = 1'b1;
            end
            FIM: begin
                s.pronto               = 1'b1;
                s.mostra_tempo_de_jogo = TEMPO_EN;
                s.acertou              = f;
                s.errou                = ~f;
            end
            default: s = '0;
        endcase
        return s;
    endfunction

    always_comb begin
        estado_d = estado_q;
        erros_d  = erros_q;
        flag_d   = flag_q;
        case (estado_q)
            INICIAL:  if (bus.iniciar) estado_d = PREPARA;
            PREPARA: begin
                erros_d  = '0;
                flag_d   = 1'b0;
                estado_d = ESPERA;
            end
            ESPERA: begin
                if (bus.fez_jogada)       estado_d = REGISTRA;
                else if (bus.deu_timeout) estado_d = ERRO;
            end
            REGISTRA: estado_d = COMPARA;
            COMPARA:  estado_d = bus.jogada_igual_memoria ? ACERTO : ERRO;
            ACERTO: begin
                flag_d   = 1'b1;
                estado_d = MOSTRA;
            end
            ERRO: begin
                flag_d   = 1'b0;
                erros_d  = incr_sat(erros_q);
                estado_d = MOSTRA;
            end
            MOSTRA: begin
                if (bus.fim_timer_resultado) begin
                    if (erros_q == MAX_ERROS_4 || bus.ultima_jogada) estado_d = FIM;
                    else                                             estado_d = PROXIMA;
                end
            end
            PROXIMA:  estado_d = ESPERA;
            FIM:      if (bus.iniciar) estado_d = PREPARA;
            default:  estado_d = INICIAL;
        endcase
        saidas_d = decodifica(estado_d, flag_d);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            estado_q <= INICIAL;
            erros_q  <= '0;
            flag_q   <= 1'b0;
            saidas_q <= '0;
        end else begin
            estado_q <= estado_d;
            erros_q  <= erros_d;
            flag_q   <= flag_d;
            saidas_q <= saidas_d;
        end
    end

    assign bus.zera_contador_jogada  = saidas_q.zera_contador_jogada;
    assign bus.zera_contador_score   = saidas_q.zera_contador_score;
    assign bus.zera_timer_resultado  = saidas_q.zera_timer_resultado;
    assign bus.zera_timeout          = saidas_q.zera_timeout;
    assign bus.zeraR                 = saidas_q.zeraR;
    assign bus.zera_tempo_de_jogo    = saidas_q.zera_tempo_de_jogo;
    assign bus.conta_jogada          = saidas_q.conta_jogada;
    assign bus.conta_score           = saidas_q.conta_score;
    assign bus.conta_timer_resultado = saidas_q.conta_timer_resultado;
    assign bus.conta_timeout         = saidas_q.conta_timeout;
    assign bus.registraR             = saidas_q.registraR;
    assign bus.liga_led              = saidas_q.liga_led;
    assign bus.mostra_tempo_de_jogo  = saidas_q.mostra_tempo_de_jogo;
    assign bus.acertou               = saidas_q.acertou;
    assign bus.errou                 = saidas_q.errou;
    assign bus.pronto                = saidas_q.pronto;
    assign bus.db_estado             = estado_q;

endmodule

// File: tb/tb_unidade_controle_geogenius.sv
// Bench for unidade_controle_geogenius: scripted and random games checked cycle by cycle.
`timescale 1ns/1ps
module tb_unidade_controle_geogenius;

`ifdef GEOGENIUS_TEMPO_DE_JOGO_EN
    localparam bit TJ = 1'b1;
`else
    localparam bit TJ = 1'b0;
`endif

    // expected-state codes and input bit positions {iniciar,fez,igual,timeout,ultima,fim}
    localparam int S_INI = 0, S_PREP = 1, S_ESP = 2, S_REG = 3, S_CMP = 4;
    localparam int S_ACE = 5, S_ERR = 6, S_MOS = 7, S_PROX = 8, S_FIM = 9;
    localparam logic [5:0] I_INI = 6'b100000, I_FEZ = 6'b010000, I_IGU = 6'b001000;
    localparam logic [5:0] I_TO  = 6'b000100, I_ULT = 6'b000010, I_FIMT = 6'b000001;

    typedef struct {
        int         st;
        bit         fl;
        logic [5:0] ins;
    } ent_t;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    unidade_controle_geogenius_if if0 ();
    unidade_controle_geogenius_if if1 ();

    unidade_controle_geogenius #(.MAX_ERROS(1)) u0 (.clock(clock), .reset(reset), .bus(if0));
    unidade_controle_geogenius #(.MAX_ERROS(3)) u1 (.clock(clock), .reset(reset), .bus(if1));

    logic [19:0] obs0, obs1;
    assign obs0 = {if0.db_estado, if0.zera_contador_jogada, if0.zera_contador_score,
                   if0.zera_timer_resultado, if0.zera_timeout, if0.zeraR, if0.zera_tempo_de_jogo,
                   if0.conta_jogada, if0.conta_score, if0.conta_timer_resultado, if0.conta_timeout,
                   if0.registraR, if0.liga_led, if0.mostra_tempo_de_jogo,
                   if0.acertou, if0.errou, if0.pronto};
    assign obs1 = {if1.db_estado, if1.zera_contador_jogada, if1.zera_contador_score,
                   if1.zera_timer_resultado, if1.zera_timeout, if1.zeraR, if1.zera_tempo_de_jogo,
                   if1.conta_jogada, if1.conta_score, if1.conta_timer_resultado, if1.conta_timeout,
                   if1.registraR, if1.liga_led, if1.mostra_tempo_de_jogo,
                   if1.acertou, if1.errou, if1.pronto};

    int   total = 0;
    int   bad   = 0;
    ent_t tr[$];
    int   m_err;
    int   m_max;
    bit   last_res;

    // Expected output word for a state, written from the per-state strobe list of the game rules.
    function automatic logic [19:0] exp_vec(input int st, input bit fl);
        logic [15:0] o;
        logic [3:0]  s4;
        o  = '0;
        s4 = st[3:0];
        case (st)
            S_PREP: begin o[15] = 1; o[14] = 1; o[13] = 1; o[12] = 1; o[11] = 1; o[10] = TJ; end
            S_ESP:  begin o[6] = 1; o[4] = 1; end
            S_REG:  begin o[5] = 1; o[12] = 1; end
            S_ACE:  begin o[8] = 1; o[13] = 1; end
            S_ERR:  begin o[13] = 1; o[12] = 1; end
            S_MOS:  begin o[7] = 1; o[2] = fl; o[1] = !fl; end
            S_PROX: begin o[9] = 1; o[12] = 1; o[11] = 1; end
            S_FIM:  begin o[0] = 1; o[3] = TJ; o[2] = fl; o[1] = !fl; end
            default: o = '0;
        endcase
        return {s4, o};
    endfunction

    // Inputs a state does not look at are filled with random noise.
    task automatic add(input int st, input bit fl, input logic [5:0] ins);
        logic [5:0] care;
        ent_t       e;
        case (st)
            S_INI, S_FIM: care = I_INI;
            S_ESP:        care = I_FEZ | I_TO;
            S_CMP:        care = I_IGU;
            S_MOS:        care = I_ULT | I_FIMT;
            default:      care = 6'b0;
        endcase
        e.st  = st;
        e.fl  = fl;
        e.ins = (ins & care) | (6'($urandom) & ~care);
        tr.push_back(e);
    endtask

    task automatic push_play(input bit to, input bit ok, input bit both, input int w,
                             input int m, input bit ult, output bit done);
        bit res;
        for (int i = 0; i < w; i++) add(S_ESP, 0, 6'b0);
        if (to) begin
            add(S_ESP, 0, I_TO);
            res = 1'b0;
        end else begin
            add(S_ESP, 0, both ? (I_FEZ | I_TO) : I_FEZ);
            add(S_REG, 0, 6'b0);
            add(S_CMP, 0, ok ? I_IGU : 6'b0);
            res = ok;
        end
        add(res ? S_ACE : S_ERR, 0, 6'b0);
        if (!res && m_err < 15) m_err++;
        for (int i = 0; i < m; i++) add(S_MOS, res, 6'b0);
        add(S_MOS, res, ult ? (I_FIMT | I_ULT) : I_FIMT);
        done = (m_err == m_max) || ult;
        add(done ? S_FIM : S_PROX, res, 6'b0);
        last_res = res;
    endtask

    task automatic start_game();
        add(S_INI, 0, I_INI);
        add(S_PREP, 0, 6'b0);
        m_err = 0;
    endtask

    task automatic drive_zero();
        {if0.iniciar, if0.fez_jogada, if0.jogada_igual_memoria, if0.deu_timeout,
         if0.ultima_jogada, if0.fim_timer_resultado} = 6'b0;
        {if1.iniciar, if1.fez_jogada, if1.jogada_igual_memoria, if1.deu_timeout,
         if1.ultima_jogada, if1.fim_timer_resultado} = 6'b0;
    endtask

    task automatic do_reset();
        tr.delete();
        drive_zero();
        @(negedge clock) reset = 1'b0;
        @(negedge clock) reset = 1'b1;
    endtask

    // Samples the selected DUT at the falling edge, then applies its next inputs.
    task automatic step(input int sel, input logic [5:0] ins, output logic [19:0] obs);
        @(negedge clock);
        obs = (sel == 0) ? obs0 : obs1;
        {if0.iniciar, if0.fez_jogada, if0.jogada_igual_memoria, if0.deu_timeout,
         if0.ultima_jogada, if0.fim_timer_resultado} = (sel == 0) ? ins : 6'b0;
        {if1.iniciar, if1.fez_jogada, if1.jogada_igual_memoria, if1.deu_timeout,
         if1.ultima_jogada, if1.fim_timer_resultado} = (sel == 1) ? ins : 6'b0;
    endtask

    task automatic test_reset();
        logic [19:0] obs;
        ent_t        e;
        int          cyc = 0;
        reset = 1'b1;
        drive_zero();
        #1 reset = 1'b0;
        #2;
        total++;
        if (obs0 !== 20'h0 || obs1 !== 20'h0) begin
            bad++;
            $display("FAIL reset_init got=%h/%h want=00000", obs0, obs1);
        end
        @(negedge clock) reset = 1'b1;
        m_max = 1;
        start_game();
        add(S_ESP, 0, I_FEZ);
        add(S_REG, 0, 6'b0);
        add(S_CMP, 0, I_IGU);
        add(S_ACE, 0, 6'b0);
        for (int i = 0; i < 3; i++) add(S_MOS, 1, 6'b0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(0, e.ins, obs);
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL reset_pre cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
        #2 reset = 1'b0;
        drive_zero();
        #1;
        total++;
        if (obs0 !== 20'h0) begin
            bad++;
            $display("FAIL reset_async got=%h want=00000", obs0);
        end
        @(negedge clock);
        total++;
        if (obs0 !== 20'h0) begin
            bad++;
            $display("FAIL reset_hold got=%h want=00000", obs0);
        end
        reset = 1'b1;
        add(S_INI, 0, 6'b0);
        add(S_INI, 0, 6'b0);
        start_game();
        add(S_ESP, 0, 6'b0);
        add(S_ESP, 0, 6'b0);
        cyc = 0;
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(0, e.ins, obs);
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL reset_post cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
    endtask

    task automatic test_correct_play();
        logic [19:0] obs;
        ent_t        e;
        bit          done;
        int          cyc = 0;
        do_reset();
        m_max = 1;
        start_game();
        push_play(0, 1, 0, $urandom_range(0, 3), $urandom_range(1, 6), 0, done);
        push_play(0, 1, 0, $urandom_range(0, 3), $urandom_range(1, 6), 0, done);
        push_play(1, 0, 0, $urandom_range(0, 3), $urandom_range(1, 6), 0, done);
        add(S_FIM, last_res, 6'b0);
        add(S_FIM, last_res, 6'b0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(0, e.ins, obs);
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL correct_play cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
    endtask

    task automatic test_timeout_restart();
        logic [19:0] obs;
        ent_t        e;
        bit          done;
        int          cyc = 0;
        do_reset();
        m_max = 1;
        start_game();
        push_play(1, 0, 0, 2, 3, 0, done);
        for (int i = 0; i < 3; i++) add(S_FIM, last_res, 6'b0);
        add(S_FIM, last_res, I_INI);
        add(S_PREP, 0, 6'b0);
        m_err = 0;
        push_play(0, 1, 0, 1, 2, 0, done);
        push_play(1, 0, 0, 0, 2, 0, done);
        add(S_FIM, last_res, I_INI);
        add(S_PREP, 0, 6'b0);
        add(S_ESP, 0, 6'b0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(0, e.ins, obs);
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL timeout_restart cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
    endtask

    task automatic test_play_and_timeout();
        logic [19:0] obs;
        ent_t        e;
        bit          done;
        int          cyc = 0;
        do_reset();
        m_max = 1;
        start_game();
        push_play(0, 1, 1, 1, 2, 0, done);
        push_play(0, 1, 1, 0, 1, 0, done);
        push_play(0, 0, 1, 2, 2, 0, done);
        add(S_FIM, last_res, 6'b0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(0, e.ins, obs);
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL play_and_timeout cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
    endtask

    task automatic test_max3_round();
        logic [19:0] obs;
        ent_t        e;
        bit          done;
        int          w1, w2;
        int          exp_score = 0;
        int          score_cnt = 0;
        int          cyc = 0;
        do_reset();
        m_max = 3;
        start_game();
        w1 = $urandom_range(0, 6);
        w2 = $urandom_range(w1 + 1, 7);
        for (int p = 0; p < 8; p++) begin
            if (p == w1 || p == w2) begin
                push_play($urandom_range(0, 1), 0, 0, $urandom_range(0, 2), $urandom_range(0, 3), p == 7, done);
            end else begin
                push_play(0, 1, $urandom_range(0, 1), $urandom_range(0, 2), $urandom_range(0, 3), p == 7, done);
                exp_score++;
            end
        end
        add(S_FIM, last_res, 6'b0);
        while (tr.size() > 0) begin
            e = tr.pop_front();
            step(1, e.ins, obs);
            if (obs[8]) score_cnt++;
            total++;
            if (obs !== exp_vec(e.st, e.fl)) begin
                bad++;
                $display("FAIL max3_round cyc=%0d got=%h want=%h", cyc, obs, exp_vec(e.st, e.fl));
            end
            cyc++;
        end
        total++;
        if (score_cnt !== exp_score) begin
            bad++;
            $display("FAIL max3_score got=%0d want=%0d", score_cnt, exp_score);
        end
    endtask

    task automatic test_random_games();
        logic [19:0] obs;
        ent_t        e;
        bit          done;
        int          cyc;
        for (int sel = 0; sel < 2; sel++) begin
            do_reset();
            m_max = (sel == 0) ? 1 : 3;
            for (int g = 0; g < 4; g++) begin
                if (g == 0) start_game();
                else begin
                    add(S_FIM, last_res, I_INI);
                    add(S_PREP, 0, 6'b0);
                    m_err = 0;
                end
                done = 0;
                for (int p = 0; p < 8 && !done; p++) begin
                    push_play($urandom_range(0, 5) == 0, $urandom_range(0, 3) != 0,
                              $urandom_range(0, 1), $urandom_range(0, 3),
                              $urandom_range(0, 4), p == 7, done);
                end
                for (int i = 0; i < int'($urandom_range(0, 2)); i++) add(S_FIM, last_res, 6'b0);
            end
            cyc = 0;
            while (tr.size() > 0) begin
                e = tr.pop_front();
                step(sel, e.ins, obs);
                total++;
                if (obs !== exp_vec(e.st, e.fl)) begin
                    bad++;
                    $display("FAIL random_games dut=%0d cyc=%0d got=%h want=%h",
                             sel, cyc, obs, exp_vec(e.st, e.fl));
                end
                cyc++;
            end
        end
    endtask

    initial begin
        test_reset();
        test_correct_play();
        test_timeout_restart();
        test_play_and_timeout();
        test_max3_round();
        test_random_games();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/unidade_controle_geogenius.md
# unidade_controle_geogenius

Moore control unit that sequences the game datapath (`fluxo_de_dados`) through one 8-play round. It drives every zera/conta/registra/liga strobe of the datapath and consumes its status flags. It also tracks errors against a configurable limit and presents acertou/errou/pronto and debug state to the top level.

## Interface
- `MAX_ERROS`, default 1: number of errors (wrong play or timeout) that ends the game; legal range 1..15.
- `clock`  input  1  system clock, rising edge.
- `reset`  input  1  asynchronous, active-low reset.
- `iniciar`  input  1  start request; level-sampled.
- `fez_jogada`, `jogada_igual_memoria`, `deu_timeout`, `ultima_jogada`, `fim_timer_resultado`  input  1 each  datapath status.
- `zera_contador_jogada`, `zera_contador_score`, `zera_timer_resultado`, `zera_timeout`, `zeraR`, `zera_tempo_de_jogo`  output  1 each  datapath clears.
- `conta_jogada`, `conta_score`, `conta_timer_resultado`, `conta_timeout`  output  1 each  datapath count enables.
- `registraR`, `liga_led`, `mostra_tempo_de_jogo`  output  1 each  datapath register/display enables.
- `acertou`, `errou`, `pronto`  output  1 each  result and end-of-game indications.
- `db_estado`  output  4  current state code.

## Operation
State codes: INICIAL=0, PREPARA=1, ESPERA=2, REGISTRA=3, COMPARA=4, ACERTO=5, ERRO=6, MOSTRA=7, PROXIMA=8, FIM=9. Codes 10..15 are illegal and go to INICIAL.

- INICIAL: all outputs 0. `iniciar` -> PREPARA.
- PREPARA: asserts all six zera_* outputs. Clears the internal error counter and the result flag. -> ESPERA.
- ESPERA: asserts `liga_led` and `conta_timeout`.
  - `fez_jogada` -> REGISTRA.
  - Else `deu_timeout` -> ERRO.
  - If both are high, `fez_jogada` wins.
- REGISTRA: asserts `registraR` and `zera_timeout`. -> COMPARA.
- COMPARA: no strobes. `jogada_igual_memoria` -> ACERTO, else -> ERRO.
- ACERTO (1 cycle): asserts `conta_score` and `zera_timer_resultado`. Sets the result flag to 1. -> MOSTRA.
- ERRO (1 cycle): asserts `zera_timer_resultado` and `zera_timeout`. Sets the result flag to 0. Increments the error counter (4-bit, saturating at 15). -> MOSTRA.
- MOSTRA: asserts `conta_timer_resultado`. `acertou` = flag and `errou` = ~flag. On `fim_timer_resultado`:
  - erros == MAX_ERROS -> FIM.
  - Else `ultima_jogada` -> FIM.
  - Else -> PROXIMA.
- PROXIMA (1 cycle): asserts `conta_jogada`, `zera_timeout` and `zeraR`. -> ESPERA.
- FIM: asserts `pronto` and `mostra_tempo_de_jogo`. `acertou`/`errou` hold the last result. `iniciar` -> PREPARA.

## Timing
- State register and the error/flag registers reset asynchronously on `reset`=0 to: INICIAL, 0, 0.
- All outputs are decoded from the registered state only (pure Moore), so every output is 0 during reset. Status inputs affect outputs one cycle later.
- Every one-cycle state (PREPARA, REGISTRA, ACERTO, ERRO, PROXIMA) holds its strobe for exactly one clock.
- The datapath register loads at the REGISTRA→COMPARA edge. The comparison in COMPARA therefore sees the new value.
- Minimum path from a play to the result display: ESPERA → REGISTRA → COMPARA → ACERTO/ERRO → MOSTRA, i.e. 4 clocks after `fez_jogada` is sampled.
- MOSTRA lasts until `fim_timer_resultado`, which is 2000 counts.
- The error check in MOSTRA has priority over the `ultima_jogada` check. Both lead to FIM.
- `iniciar` held high through FIM restarts immediately; there is no edge requirement.
- An asynchronous reset at any point returns to INICIAL in the same cycle.

## Configuration
- `GEOGENIUS_TEMPO_DE_JOGO_EN` defined: `zera_tempo_de_jogo` and `mostra_tempo_de_jogo` are driven as described above.
- Not defined: both ports remain on the interface but are tied to constant 0. The FSM is otherwise identical.

## Structure
- Shared package `geogenius_pkg` holds the state enum type (4-bit, codes above) and the default `MAX_ERROS` constant. The datapath debug decoder reuses the same enum.
- Single module; no sub-module is warranted. Next-state logic, output decode, error counter and result flag all live here.

## Test plan
- Reset with `reset`=0 mid-MOSTRA -> `db_estado`=0 and all outputs 0 immediately. Release plus `iniciar`=1 -> PREPARA with all six zera_* high for 1 cycle, then ESPERA (`liga_led`=1).
- Correct play (`fez_jogada`=1, then `jogada_igual_memoria`=1 in COMPARA) -> `registraR` pulses 1 cycle, `conta_score` pulses 1 cycle, `acertou`=1 until `fim_timer_resultado`, then PROXIMA with `conta_jogada`=1 for 1 cycle.
- `deu_timeout`=1 in ESPERA, MAX_ERROS=1 -> ERRO, MOSTRA with `errou`=1, then FIM with `pronto`=1 and `db_estado`=9.
- `fez_jogada` and `deu_timeout` high in the same cycle -> REGISTRA is taken; no error is counted.
- MAX_ERROS=3, eight plays with 2 wrong and `ultima_jogada`=1 on the 8th -> FIM after the 8th MOSTRA. `conta_score` pulses exactly 6 times.
- Build without `GEOGENIUS_TEMPO_DE_JOGO_EN` -> `mostra_tempo_de_jogo`=0 in FIM and `zera_tempo_de_jogo`=0 in PREPARA.
